// File: rtl/alu_seq_pkg.sv
// Shared constants, FSM states and request decode for the sequential ALU control.
// Mult/div support is enabled by defining ALU_SEQ_MULDIV_EN.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   localparam logic [3:0] CTL_AND   = 4'b0000;
   localparam logic [3:0] CTL_OR    = 4'b0001;
   localparam logic [3:0] CTL_ADD   = 4'b0010;
   localparam logic [3:0] CTL_SUB   = 4'b0110;
   localparam logic [3:0] CTL_SLT   = 4'b0111;
   localparam logic [3:0] CTL_NOR   = 4'b1100;
   localparam logic [3:0] CTL_MULT  = 4'b1000;
   localparam logic [3:0] CTL_MULTU = 4'b1001;
   localparam logic [3:0] CTL_DIV   = 4'b1010;
   localparam logic [3:0] CTL_DIVU  = 4'b1011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       illegal;
      logic       muldiv;
      logic       is_div;
      logic       is_signed;
   } dec_t;

   localparam dec_t DEC_ILLEGAL = '{
      ctrl: CTL_AND, illegal: 1'b1, muldiv: 1'b0,
      is_div: 1'b0, is_signed: 1'b0
   };

   function automatic dec_t alu_decode(input logic [1:0] op,
                                       input logic [5:0] fn);
      dec_t d;
      d = '0;
      case (op)
         OP_ADD:   d.ctrl = CTL_ADD;
         OP_SUB:   d.ctrl = CTL_SUB;
         OP_RTYPE: begin
            case (fn)
               FN_ADD, FN_ADDU: d.ctrl = CTL_ADD;
               FN_SUB, FN_SUBU: d.ctrl = CTL_SUB;
               FN_AND:  d.ctrl = CTL_AND;
               FN_OR:   d.ctrl = CTL_OR;
               FN_NOR:  d.ctrl = CTL_NOR;
               FN_SLT:  d.ctrl = CTL_SLT;
               FN_MULT: d = '{CTL_MULT, 1'b0, 1'b1, 1'b0, 1'b1};
               FN_MULTU: d = '{CTL_MULTU, 1'b0, 1'b1, 1'b0, 1'b0};
               FN_DIV:  d = '{CTL_DIV, 1'b0, 1'b1, 1'b1, 1'b1};
               FN_DIVU: d = '{CTL_DIVU, 1'b0, 1'b1, 1'b1, 1'b0};
               default: d = DEC_ILLEGAL;
            endcase
         end
         default:  d = DEC_ILLEGAL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 shift-add multiplier / restoring divider on magnitudes,
// with sign fix-up applied to the result of the final step.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_signed,
   input  logic                  i_div,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW);

   logic          r_busy;
   logic          r_div;
   logic          r_neg_q;
   logic          r_neg_r;
   logic [CW-1:0] r_cnt;
   logic [DW:0]   r_acc;
   logic [DW-1:0] r_q;
   logic [DW-1:0] r_m;

   logic          w_a_neg;
   logic          w_b_neg;
   logic [DW-1:0] w_a_mag;
   logic [DW-1:0] w_b_mag;
   logic [DW:0]   w_add;
   logic [DW:0]   w_shl;
   logic [DW:0]   w_diff;
   logic [DW:0]   w_acc_n;
   logic [DW-1:0] w_q_n;
   logic [2*DW-1:0] w_prod;
   logic [2*DW-1:0] w_prod_s;

   assign w_a_neg = i_signed & i_a[DW-1];
   assign w_b_neg = i_signed & i_b[DW-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   always_comb begin
      w_add   = r_q[0] ? (r_acc + {1'b0, r_m}) : r_acc;
      w_shl   = {r_acc[DW-1:0], r_q[DW-1]};
      w_diff  = w_shl - {1'b0, r_m};
      w_acc_n = {1'b0, w_add[DW:1]};
      w_q_n   = {w_add[0], r_q[DW-1:1]};
      if (r_div) begin
         // Top bit of the difference set means the trial subtract borrowed
         w_acc_n = w_diff[DW] ? w_shl : w_diff;
         w_q_n   = {r_q[DW-2:0], ~w_diff[DW]};
      end
   end

   assign w_prod   = {w_acc_n[DW-1:0], w_q_n};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;

   always_comb begin
      o_hi = w_prod_s[2*DW-1:DW];
      o_lo = w_prod_s[DW-1:0];
      if (r_div) begin
         o_lo = r_neg_q ? -w_q_n : w_q_n;
         o_hi = r_neg_r ? -w_acc_n[DW-1:0] : w_acc_n[DW-1:0];
      end
   end

   assign o_done = r_busy & (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_m     <= '0;
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_div   <= i_div;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_cnt   <= CW'(DW - 1);
         r_acc   <= '0;
         r_q     <= w_a_mag;
         r_m     <= w_b_mag;
      end else if (r_busy) begin
         r_acc <= w_acc_n;
         r_q   <= w_q_n;
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == '0) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_control.sv
// ALU control decoder with valid/ready handshake and optional iterative
// mult/div unit (enabled by ALU_SEQ_MULDIV_EN).
module alu_seq_control
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            alu_op,
   input  logic [5:0]            funct,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            alu_control,
   output logic                  illegal,
   output logic                  div0,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_ctrl;
   logic       r_illegal;
   dec_t       w_dec;
   logic       w_accept;
   logic       w_start;
   logic       w_md_done;

   always_comb begin
      w_dec = alu_decode(alu_op, funct);
`ifndef ALU_SEQ_MULDIV_EN
      if (w_dec.muldiv) w_dec = DEC_ILLEGAL;
`endif
   end

   assign in_ready = rst_n & ((r_state == S_IDLE) |
                              ((r_state == S_DONE) & out_ready));
   assign w_accept = in_valid & in_ready;
   assign out_valid = (r_state == S_DONE);
   assign alu_control = r_ctrl;
   assign illegal = r_illegal & out_valid;

   always_comb begin
      w_next = r_state;
      if (w_accept) begin
         w_next = w_start ? S_RUN : S_DONE;
      end else begin
         unique case (r_state)
            S_IDLE: w_next = S_IDLE;
            S_RUN:  if (w_md_done) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ctrl    <= CTL_AND;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_ctrl    <= w_dec.ctrl;
            r_illegal <= w_dec.illegal;
         end
      end
   end

`ifdef ALU_SEQ_MULDIV_EN
   logic                  w_div0;
   logic                  r_div0;
   logic [DATA_WIDTH-1:0] r_hi;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [DATA_WIDTH-1:0] w_md_hi;
   logic [DATA_WIDTH-1:0] w_md_lo;

   // Divide by zero never enters the iterative path
   assign w_div0  = w_dec.muldiv & w_dec.is_div & (src_b == '0);
   assign w_start = w_accept & w_dec.muldiv & ~w_div0;

   alu_seq_muldiv #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_signed(w_dec.is_signed),
      .i_div   (w_dec.is_div),
      .i_a     (src_a),
      .i_b     (src_b),
      .o_done  (w_md_done),
      .o_hi    (w_md_hi),
      .o_lo    (w_md_lo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div0 <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else begin
         if (w_accept) r_div0 <= w_div0;
         if (w_accept && w_div0) begin
            r_hi <= src_a;
            r_lo <= '1;
         end else if (r_state == S_RUN && w_md_done) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
         end
      end
   end

   assign div0 = r_div0 & out_valid;
   assign hi   = r_hi;
   assign lo   = r_lo;
`else
   logic w_unused_ops;

   assign w_unused_ops = ^{src_a, src_b, w_dec.is_div, w_dec.is_signed};
   assign w_start   = 1'b0;
   assign w_md_done = 1'b0;
   assign div0      = 1'b0;
   assign hi        = '0;
   assign lo        = '0;
`endif

endmodule

// File: tb/tb_alu_seq_control.sv
// Directed self-checking bench for alu_seq_control; mult/div scenarios
// are compiled in when ALU_SEQ_MULDIV_EN is defined.
module tb_alu_seq_control;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    alu_op;
   logic [5:0]    funct;
   logic [DW-1:0] src_a;
   logic [DW-1:0] src_b;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    alu_control;
   logic          illegal;
   logic          div0;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_control #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .funct      (funct),
      .src_a      (src_a),
      .src_b      (src_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_control(alu_control),
      .illegal    (illegal),
      .div0       (div0),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
      alu_op   = op;
      funct    = fn;
      src_a    = a;
      src_b    = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      alu_op    = 2'b00;
      funct     = 6'b0;
      src_a     = '0;
      src_b     = '0;
      step();
      step();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      checks++;
      if ({out_valid, alu_control, illegal, div0} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outs got v=%b c=%b i=%b d=%b want 0",
                  out_valid, alu_control, illegal, div0);
      end
      checks++;
      if ({hi, lo} !== '0) begin
         errors++;
         $display("FAIL reset_hilo got %h %h want 0", hi, lo);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_decode();
      logic [1:0] ops [12] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [5:0] fns [12] = '{6'b000000, 6'b111111, 6'b100000,
                               6'b100000, 6'b100001, 6'b100010,
                               6'b100011, 6'b100100, 6'b100101,
                               6'b100111, 6'b101010, 6'b100110};
      logic [3:0] ctl [12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0010,
                               4'b0010, 4'b0110, 4'b0110, 4'b0000,
                               4'b0001, 4'b1100, 4'b0111, 4'b0000};
      logic       ill [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         issue(ops[i], fns[i], 32'h1234, 32'h0);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL decode%0d out_valid got %b want 1", i, out_valid);
         end
         checks++;
         if (alu_control !== ctl[i]) begin
            errors++;
            $display("FAIL decode%0d alu_control got %b want %b",
                     i, alu_control, ctl[i]);
         end
         checks++;
         if (illegal !== ill[i]) begin
            errors++;
            $display("FAIL decode%0d illegal got %b want %b",
                     i, illegal, ill[i]);
         end
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode%0d drain out_valid got %b want 0",
                     i, out_valid);
         end
      end
   endtask

   task automatic test_hold();
      out_ready = 1'b0;
      issue(2'b10, 6'b111111, '0, '0);
      alu_op   = 2'b00;
      funct    = 6'b100000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, alu_control, illegal, in_ready} !== 7'b1_0000_1_0)
         begin
            errors++;
            $display("FAIL hold%0d got v=%b c=%b i=%b r=%b want 1 0000 1 0",
                     i, out_valid, alu_control, illegal, in_ready);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, illegal, in_ready} !== 3'b001) begin
         errors++;
         $display("FAIL hold_release got v=%b i=%b r=%b want 0 0 1",
                  out_valid, illegal, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      alu_op    = 2'b00;
      funct     = 6'b0;
      in_valid  = 1'b1;
      step();
      checks++;
      if ({out_valid, alu_control, in_ready} !== 6'b1_0010_1) begin
         errors++;
         $display("FAIL b2b_add got v=%b c=%b r=%b want 1 0010 1",
                  out_valid, alu_control, in_ready);
      end
      alu_op = 2'b01;
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, alu_control} !== 5'b1_0110) begin
         errors++;
         $display("FAIL b2b_sub got v=%b c=%b want 1 0110",
                  out_valid, alu_control);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain out_valid got %b want 0", out_valid);
      end
   endtask

`ifdef ALU_SEQ_MULDIV_EN
   task automatic test_muldiv();
      int n;
      out_ready = 1'b1;
      issue(2'b10, 6'b011000, -32'sd3, 32'd7);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mult_run_ready got %b want 0", in_ready);
      end
      n = 1;
      while (out_valid !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (n !== 33) begin
         errors++;
         $display("FAIL mult_latency got %0d want 33", n);
      end
      checks++;
      if ({hi, lo, alu_control, illegal} !== {32'hFFFFFFFF, 32'hFFFFFFEB,
                                               4'b1000, 1'b0}) begin
         errors++;
         $display("FAIL mult_result got %h %h c=%b i=%b want ffffffff ffffffeb 1000 0",
                  hi, lo, alu_control, illegal);
      end
      step();
      issue(2'b00, 6'b0, 32'h5, 32'h5);
      checks++;
      if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
         errors++;
         $display("FAIL hilo_keep got %h %h want ffffffff ffffffeb", hi, lo);
      end
      step();
      issue(2'b10, 6'b011010, -32'sd7, 32'd2);
      n = 1;
      while (out_valid !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if ({hi, lo, div0} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0} || n !== 33)
      begin
         errors++;
         $display("FAIL div_result got %h %h d=%b n=%0d want ffffffff fffffffd 0 33",
                  hi, lo, div0, n);
      end
      step();
      issue(2'b10, 6'b011011, 32'd100, 32'd0);
      checks++;
      if ({out_valid, div0, alu_control, hi, lo} !==
          {1'b1, 1'b1, 4'b1011, 32'h00000064, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL divu0 got v=%b d=%b c=%b %h %h want 1 1 1011 00000064 ffffffff",
                  out_valid, div0, alu_control, hi, lo);
      end
      step();
      issue(2'b00, 6'b0, '0, '0);
      checks++;
      if (div0 !== 1'b0) begin
         errors++;
         $display("FAIL div0_clear got %b want 0", div0);
      end
      step();
   endtask

   task automatic test_reset_abort();
      out_ready = 1'b1;
      issue(2'b10, 6'b011001, 32'd5, 32'd6);
      repeat (9) step();
      rst_n = 1'b0;
      step();
      checks++;
      if ({out_valid, in_ready, hi, lo} !== '0) begin
         errors++;
         $display("FAIL abort got v=%b r=%b %h %h want 0 0 0 0",
                  out_valid, in_ready, hi, lo);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready got %b want 1", in_ready);
      end
      repeat (40) step();
      checks++;
      if ({out_valid, hi, lo} !== '0) begin
         errors++;
         $display("FAIL abort_quiet got v=%b %h %h want 0 0 0",
                  out_valid, hi, lo);
      end
   endtask
`else
   task automatic test_muldiv();
      out_ready = 1'b1;
      issue(2'b10, 6'b011000, -32'sd3, 32'd7);
      checks++;
      if ({out_valid, alu_control, illegal} !== 6'b1_0000_1) begin
         errors++;
         $display("FAIL mult_off got v=%b c=%b i=%b want 1 0000 1",
                  out_valid, alu_control, illegal);
      end
      step();
      issue(2'b10, 6'b011011, 32'd100, 32'd0);
      checks++;
      if ({out_valid, illegal, div0, hi, lo} !== {3'b110, 64'h0}) begin
         errors++;
         $display("FAIL divu_off got v=%b i=%b d=%b %h %h want 1 1 0 0 0",
                  out_valid, illegal, div0, hi, lo);
      end
      step();
   endtask

   task automatic test_reset_abort();
      out_ready = 1'b0;
      issue(2'b00, 6'b0, '0, '0);
      rst_n = 1'b0;
      step();
      checks++;
      if ({out_valid, in_ready, alu_control} !== 6'b0) begin
         errors++;
         $display("FAIL abort got v=%b r=%b c=%b want 0 0 0000",
                  out_valid, in_ready, alu_control);
      end
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready got %b want 1", in_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_hold();
      test_back_to_back();
      test_muldiv();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
